seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for the 8-digit common-anode 7-segment display on the demo board.
//  Sits directly downstream of the control-unit demo top.
//  Latches a 32-bit value (8 hex nibbles) plus per-digit decimal-point and enable masks.
//  Scans the digits one at a time, with a blanking gap per slot to prevent ghosting.
//  Drives hex_o / dp_o / an_o active-low.
// PARAMETERS
//  CLK_DIV  1000  clock cycles per digit slot (>= 2)
//  BLANK    16    cycles at the start of each slot with all anodes off (1 <= BLANK < CLK_DIV)
// PORTS
//  clk_i       in   1   system clock; all logic on rising edge
//  rst_i       in   1   synchronous, active-high reset
//  load_i      in   1   capture strobe for data_i/dp_i/en_i/lzs_i
//  data_i      in   32  nibble k -> digit k (digit 0 = rightmost, bits [3:0])
//  dp_i        in   8   bit k = 1 lights DP of digit k
//  en_i        in   8   bit k = 1 enables digit k
//  lzs_i       in   1   leading-zero suppression enable
//  hex_o       out  8   active-low {dp,g,f,e,d,c,b,a}
//  dp_o        out  1   active-low DP, always equal to hex_o[7]
//  an_o        out  8   active-low one-hot anode select
//  frame_o     out  1   1-cycle pulse at end of every full 8-digit scan
// BEHAVIOUR
//  State
//  - cnt: 0..CLK_DIV-1; increments every cycle, wraps to 0.
//  - dig: 0..7; advances (7 wraps to 0) on the cycle cnt == CLK_DIV-1.
//  Shadow registers
//  - s_data, s_dp, s_en, s_lzs load on any edge with load_i = 1.
//  - Between loads the display uses only the shadow values; input changes without load_i are ignored.
//  Outputs
//  - All outputs are registers, computed each edge from current cnt/dig/shadow (1-cycle latency).
//  - cnt < BLANK: an_o = 8'hFF, hex_o = 8'hFF, dp_o = 1.
//  - Otherwise, digit dig is visible if s_en[dig] = 1 and it is not suppressed.
//    - Visible: an_o = ~(8'b1 << dig), hex_o[6:0] = seg(s_data nibble dig), hex_o[7] = dp_o = ~s_dp[dig].
//    - Not visible: an_o = hex_o = 8'hFF, dp_o = 1. The slot still consumes CLK_DIV cycles (constant duty).
//  - seg(), active-low {g..a}:
//    - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//  - Suppression: s_lzs = 1 and every nibble from dig up to 7 is zero. Digit 0 is never suppressed.
//  - frame_o = 1 on the edge after the cycle where dig == 7 and cnt == CLK_DIV-1; 0 otherwise.
//  Reset (rst_i = 1 at an edge)
//  - cnt = 0, dig = 0, shadows = 0 (s_en = 0, so all blank).
//  - an_o = 8'hFF, hex_o = 8'hFF, dp_o = 1, frame_o = 0.
//  - Takes effect on that same edge, mid-slot or mid-scan. rst_i has priority over load_i.
//  - Scan restarts at digit 0 with a full blank interval.
//  Load timing
//  - Load mid-slot: new values take effect on outputs at the edge after capture.
//  - Slot timing (cnt/dig) is not disturbed.
//  - Back-to-back loads: last captured value wins.
// TESTING (bench uses CLK_DIV=4, BLANK=1)
//  1 Reset: rst_i high 3 edges, then low
//    -> an_o=FF, hex_o=FF, dp_o=1, frame_o=0 until first load.
//  2 Load data=32'h0123_89AF, en=FF, dp=01, lzs=0
//    -> digit0 slot: 1 blank cycle, then 3 cycles an_o=FE, hex_o=0E, dp_o=0.
//    -> digit1: an_o=FD, hex_o=88. Digit order 0..7; slot pattern repeats.
//  3 Steady scan -> frame_o pulses exactly once every 32 cycles.
//    -> an_o never shows 2 zero bits, and is never FF outside blank/disabled slots.
//  4 data=32'h0000_0050, lzs=1, en=FF
//    -> digit0 hex_o=C0, digit1 hex_o=92, digits 2..7 slots an_o=FF.
//    -> with lzs=0, digit2 shows C0.
//  5 en=8'hF0 -> slots 0..3 all-off for 4 cycles each, slots 4..7 lit; frame period unchanged at 32.
//  6 Load mid-slot, then rst_i mid-digit5
//    -> new glyph appears 1 edge after capture.
//    -> reset edge forces an_o=FF and clears shadow; next slot is digit0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle for the 8-digit scan driver: capture strobe, display payload
// and the active-low display pins driven back by the driver.
interface seg7_scan_driver_if;
    logic        load_i;
    logic [31:0] data_i;
    logic [7:0]  dp_i;
    logic [7:0]  en_i;
    logic        lzs_i;
    logic [7:0]  hex_o;
    logic        dp_o;
    logic [7:0]  an_o;
    logic        frame_o;

    modport master (
        output load_i, data_i, dp_i, en_i, lzs_i,
        input  hex_o, dp_o, an_o, frame_o
    );

    modport slave (
        input  load_i, data_i, dp_i, en_i, lzs_i,
        output hex_o, dp_o, an_o, frame_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: scans 8 digits from shadowed
// data, with a blanking gap at the start of each slot and optional zero blanking.
module seg7_scan_driver #(
    parameter int CLK_DIV = 1000,
    parameter int BLANK   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    seg7_scan_driver_if.slave   bus
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    dig_reg, dig_next;
    logic [31:0]   s_data_reg;
    logic [7:0]    s_dp_reg;
    logic [7:0]    s_en_reg;
    logic          s_lzs_reg;
    logic [7:0]    an_reg, an_next;
    logic [7:0]    hex_reg, hex_next;
    logic          frame_reg, frame_next;

    logic [7:0]    nib_zero;
    logic [7:0]    upper_zero;
    logic [7:0]    visible;
    logic [6:0]    glyph [8];
    logic          in_blank;
    logic          slot_end;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Per-digit decode and visibility; a digit is blanked by zero suppression
    // only when it and every more significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign nib_zero[gi]   = (s_data_reg[4*gi +: 4] == 4'h0);
            assign upper_zero[gi] = &nib_zero[7:gi];
            assign glyph[gi]      = seg_decode(s_data_reg[4*gi +: 4]);
            if (gi == 0) begin : g_units
                assign visible[gi] = s_en_reg[gi];
            end else begin : g_upper
                assign visible[gi] = s_en_reg[gi] & ~(s_lzs_reg & upper_zero[gi]);
            end
        end
    endgenerate

    assign in_blank = (cnt_reg < BLANK_END);
    assign slot_end = (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next = slot_end ? '0 : cnt_reg + CW'(1);
        dig_next = slot_end ? dig_reg + 3'd1 : dig_reg;
    end

    // Output values for the next edge come from the current slot position and
    // shadow contents, giving a fixed one-cycle latency.
    always_comb begin
        an_next    = 8'hFF;
        hex_next   = 8'hFF;
        frame_next = slot_end && (dig_reg == 3'd7);
        if (!in_blank && visible[dig_reg]) begin
            an_next  = ~(8'b1 << dig_reg);
            hex_next = {~s_dp_reg[dig_reg], glyph[dig_reg]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            dig_reg    <= '0;
            s_data_reg <= '0;
            s_dp_reg   <= '0;
            s_en_reg   <= '0;
            s_lzs_reg  <= 1'b0;
            an_reg     <= 8'hFF;
            hex_reg    <= 8'hFF;
            frame_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            dig_reg   <= dig_next;
            an_reg    <= an_next;
            hex_reg   <= hex_next;
            frame_reg <= frame_next;
            if (bus.load_i) begin
                s_data_reg <= bus.data_i;
                s_dp_reg   <= bus.dp_i;
                s_en_reg   <= bus.en_i;
                s_lzs_reg  <= bus.lzs_i;
            end
        end
    end

    assign bus.an_o    = an_reg;
    assign bus.hex_o   = hex_reg;
    assign bus.dp_o    = hex_reg[7];
    assign bus.frame_o = frame_reg;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a time-indexed display model.
module tb_seg7_scan_driver;
    localparam int CLK_DIV = 4;
    localparam int BLANK   = 1;
    localparam int FRAME   = 8 * CLK_DIV;

    logic clk;
    logic rst;
    seg7_scan_driver_if bus();

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: m_tm counts cycles since reset; slot and phase follow by division.
    int          m_tm = 0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_en = '0;
    logic        m_lzs = 1'b0;
    logic [17:0] exp_vec;
    logic [6:0]  seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [17:0] got_vec();
        return {bus.an_o, bus.hex_o, bus.dp_o, bus.frame_o};
    endfunction

    // One clock edge: predicts outputs from the pre-edge model state, then
    // advances the model the same way the inputs ask the design to.
    task automatic tick();
        int pos, slot;
        logic vis;
        logic [3:0] nib;
        logic [17:0] e;
        pos  = m_tm % CLK_DIV;
        slot = (m_tm / CLK_DIV) % 8;
        nib  = 4'((m_data >> (4 * slot)) & 32'hF);
        vis  = (pos >= BLANK) && m_en[slot] &&
               !(m_lzs && slot != 0 && (m_data >> (4 * slot)) == 0);
        e = {8'hFF, 8'hFF, 1'b1, (m_tm % FRAME) == FRAME - 1};
        if (vis) e = {~(8'(1) << slot), ~m_dp[slot], seg_tab[nib], ~m_dp[slot], e[0]};
        @(posedge clk);
        if (rst) begin
            exp_vec = {8'hFF, 8'hFF, 1'b1, 1'b0};
            m_tm = 0; m_data = '0; m_dp = '0; m_en = '0; m_lzs = 1'b0;
        end else begin
            exp_vec = e;
            m_tm++;
            if (bus.load_i) begin
                m_data = bus.data_i; m_dp = bus.dp_i; m_en = bus.en_i; m_lzs = bus.lzs_i;
            end
        end
        #1;
    endtask

    task automatic load_values(input logic [31:0] d, input logic [7:0] dp,
                               input logic [7:0] en, input logic lzs);
        bus.load_i = 1'b1; bus.data_i = d; bus.dp_i = dp; bus.en_i = en; bus.lzs_i = lzs;
        tick();
        bus.load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (got_vec() !== {8'hFF, 8'hFF, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got_vec(), {8'hFF, 8'hFF, 1'b1, 1'b0});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_pattern();
        rst = 1'b1; tick(); rst = 1'b0;
        load_values(32'h0123_89AF, 8'h01, 8'hFF, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec) begin
                errors++;
                $display("FAIL pattern cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec);
            end
            if (i == 1 || i == 5) begin
                checks++;
                if ({bus.an_o, bus.hex_o, bus.dp_o} !== ((i == 1) ? {8'hFE, 8'h0E, 1'b0} : {8'hFD, 8'h88, 1'b1})) begin
                    errors++;
                    $display("FAIL pattern_digit cyc=%0d got=%h", i, {bus.an_o, bus.hex_o, bus.dp_o});
                end
            end
        end
        $display("test_pattern done data=0123_89AF");
    endtask

    task automatic test_steady();
        int last = -1;
        int now = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            now++;
            checks++;
            if (got_vec() !== exp_vec || $countones(~bus.an_o) > 1) begin
                errors++;
                $display("FAIL steady cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec);
            end
            if (bus.frame_o) begin
                if (last >= 0) begin
                    checks++;
                    if (now - last != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got=%0d exp=%0d", now - last, FRAME);
                    end
                end
                last = now;
            end
        end
        checks++;
        if (last < 0) begin
            errors++;
            $display("FAIL frame_seen got=0 exp=1");
        end
        $display("test_steady done");
    endtask

    task automatic test_lzs();
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1; tick(); rst = 1'b0;
            load_values(32'h0000_0050, 8'h00, 8'hFF, pass == 0);
            for (int i = 1; i <= FRAME; i++) begin
                tick();
                checks++;
                if (got_vec() !== exp_vec) begin
                    errors++;
                    $display("FAIL lzs%0d cyc=%0d got=%h exp=%h", pass, i, got_vec(), exp_vec);
                end
                if (i == 1 || i == 5 || i == 9) begin
                    checks++;
                    if ({bus.an_o, bus.hex_o} !== ((i == 1) ? 16'hFEC0 : (i == 5) ? 16'hFD92 :
                                                   (pass == 0) ? 16'hFFFF : 16'hFBC0)) begin
                        errors++;
                        $display("FAIL lzs_digit pass=%0d cyc=%0d got=%h", pass, i, {bus.an_o, bus.hex_o});
                    end
                end
            end
            $display("test_lzs done lzs=%0d", pass == 0);
        end
    endtask

    task automatic test_enable();
        int frames = 0;
        load_values(32'h7654_3210, 8'hA5, 8'hF0, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec) begin
                errors++;
                $display("FAIL enable cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec);
            end
            if (bus.frame_o) frames++;
        end
        checks++;
        if (frames != 2) begin
            errors++;
            $display("FAIL enable_frames got=%0d exp=2", frames);
        end
        $display("test_enable done en=F0");
    endtask

    task automatic test_midload_reset();
        load_values(32'h1111_1111, 8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 8 && (m_tm % CLK_DIV) != 1; i++) tick();
        load_values(32'h8888_8888, 8'h00, 8'hFF, 1'b0);
        checks++;
        if (bus.hex_o !== 8'hF9 || got_vec() !== exp_vec) begin
            errors++;
            $display("FAIL midload_old got=%h exp=F9", bus.hex_o);
        end
        tick();
        checks++;
        if (bus.hex_o !== 8'h80 || got_vec() !== exp_vec) begin
            errors++;
            $display("FAIL midload_new got=%h exp=80", bus.hex_o);
        end
        for (int i = 0; i < 2 * FRAME && !(((m_tm / CLK_DIV) % 8) == 5 && (m_tm % CLK_DIV) == 2); i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (got_vec() !== {8'hFF, 8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", got_vec(), {8'hFF, 8'hFF, 1'b1, 1'b0});
        end
        load_values(32'h1111_1111, 8'h00, 8'hFF, 1'b0);
        tick();
        checks++;
        if ({bus.an_o, bus.hex_o} !== 16'hFEF9) begin
            errors++;
            $display("FAIL reset_restart got=%h exp=FEF9", {bus.an_o, bus.hex_o});
        end
        $display("test_midload_reset done");
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        load_values(32'h2222_2222, 8'h00, 8'hFF, 1'b0);
        load_values(32'h3333_3333, 8'h00, 8'hFF, 1'b0);
        checks++;
        if (bus.hex_o !== 8'hA4) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=A4", bus.hex_o);
        end
        tick();
        checks++;
        if (bus.hex_o !== 8'hB0 || got_vec() !== exp_vec) begin
            errors++;
            $display("FAIL b2b_last got=%h exp=B0", bus.hex_o);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        int loads = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            bus.load_i = ($urandom_range(0, 9) == 0);
            bus.data_i = $urandom() & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 8)));
            bus.dp_i   = 8'($urandom());
            bus.en_i   = 8'($urandom()) | 8'($urandom());
            bus.lzs_i  = 1'($urandom());
            if (bus.load_i) loads++;
            tick();
            checks++;
            if (got_vec() !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec);
            end
        end
        rst = 1'b0;
        bus.load_i = 1'b0;
        $display("test_random done loads=%0d", loads);
    endtask

    initial begin
        rst = 1'b1;
        bus.load_i = 1'b0; bus.data_i = '0; bus.dp_i = '0; bus.en_i = '0; bus.lzs_i = 1'b0;
        test_reset();
        test_pattern();
        test_steady();
        test_lzs();
        test_enable();
        test_midload_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
